// File: rtl/uart_rx.sv
// UART receiver: oversamples RX_IN, majority-votes each bit at mid-bit,
// deserializes LSB first, checks optional parity and the stop bit, and
// reports each frame as a one-cycle data_valid or error pulse.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [5:0]            edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            samp_q, samp_d;
  logic [5:0]            p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_fail_q, par_fail_d;
  logic                  stop_fail_q, stop_fail_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic [5:0] half, p_sel;
  logic       last, decide, maj, exp_par, arm;

  // Next-state, counters, sampling and frame-result logic
  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    p_d         = p_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    par_fail_d  = par_fail_q;
    stop_fail_d = stop_fail_q;
    pdata_d     = pdata_q;
    dv_d        = 1'b0;
    pe_d        = 1'b0;
    se_d        = 1'b0;
    arm         = 1'b0;

    half    = {1'b0, p_q[5:1]};
    last    = (edge_q == p_q - 6'd1);
    decide  = (edge_q == half + 6'd2);
    maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    exp_par = par_typ_q ^ (^shift_q);

    case (Prescale)
      6'd16, 6'd32: p_sel = Prescale;
      default:      p_sel = 6'd8;
    endcase

    edge_d = last ? '0 : edge_q + 6'd1;
    if ((edge_q == half - 6'd1) || (edge_q == half) || (edge_q == half + 6'd1))
      samp_d = {samp_q[1:0], RX_IN};

    case (state_q)
      IDLE: begin
        edge_d = '0;
        if (!RX_IN) arm = 1'b1;
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (last) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
          else                              bit_d   = bit_q + 1'b1;
        end
      end
      PARITY: begin
        if (decide && (maj != exp_par)) par_fail_d = 1'b1;
        if (last) state_d = STOP;
      end
      STOP: begin
        if (decide && !maj) stop_fail_d = 1'b1;
        if (last) begin
          if (!par_fail_q && !stop_fail_q) begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end else begin
            pe_d = par_fail_q;
            se_d = stop_fail_q;
          end
          state_d = IDLE;
          // The final STOP cycle doubles as the first IDLE look at the line,
          // so a start bit abutting the stop bit keeps exact frame spacing.
          if (!RX_IN) arm = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arm) begin
      state_d     = START;
      edge_d      = '0;
      p_d         = p_sel;
      par_en_d    = PAR_EN;
      par_typ_d   = PAR_TYP;
      par_fail_d  = 1'b0;
      stop_fail_d = 1'b0;
    end
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      edge_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      p_q         <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_fail_q  <= 1'b0;
      stop_fail_q <= 1'b0;
      pdata_q     <= '0;
      dv_q        <= 1'b0;
      pe_q        <= 1'b0;
      se_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      p_q         <= p_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      par_fail_q  <= par_fail_d;
      stop_fail_q <= stop_fail_d;
      pdata_q     <= pdata_d;
      dv_q        <= dv_d;
      pe_q        <= pe_d;
      se_q        <= se_d;
    end
  end

  assign P_DATA       = pdata_q;
  assign data_valid   = dv_q;
  assign parity_error = pe_q;
  assign stop_error   = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives hand-built serial frames and checks
// pulse counts, pulse timing relative to the start bit, and received data.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
    .parity_error(parity_error), .stop_error(stop_error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  int         n_dv = 0, n_pe = 0, n_se = 0;
  int         pe_cyc = 0, se_cyc = 0;
  int         dv_cyc [0:63];
  logic [7:0] dv_dat [0:63];
  int         bad_chg = 0, excl = 0;
  logic [7:0] prev_pdata = '0;

  always @(negedge CLK) begin
    if (data_valid) begin
      if (n_dv < 64) begin
        dv_cyc[n_dv] = cyc;
        dv_dat[n_dv] = P_DATA;
      end
      n_dv = n_dv + 1;
      if (parity_error || stop_error) excl = excl + 1;
    end
    if (parity_error) begin n_pe = n_pe + 1; pe_cyc = cyc; end
    if (stop_error)   begin n_se = n_se + 1; se_cyc = cyc; end
    if (RST && !data_valid && (P_DATA !== prev_pdata)) bad_chg = bad_chg + 1;
    prev_pdata = P_DATA;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic pb, input logic sb, output int st);
    st = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pb, p);
    drive_bit(sb, p);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int st, st2, b_dv, b_pe, b_se;

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    check("rst_pdata", P_DATA, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_pe", parity_error, 0);
    check("rst_se", stop_error, 0);
    @(posedge CLK); #1 RST = 1'b1;
    idle(5);

    // Good frame, P=8, even parity (0xA5 has four ones -> parity 0)
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, st);
    idle(6);
    check("even_dv_cnt", n_dv - b_dv, 1);
    check("even_dv_cyc", dv_cyc[n_dv-1] - st, 89);
    check("even_data", dv_dat[n_dv-1], 8'hA5);
    check("even_err", (n_pe - b_pe) + (n_se - b_se), 0);

    // P=32, odd parity: 0xA5 then 0x3C good, then 0xA5 with wrong parity
    Prescale = 6'd32; PAR_TYP = 1'b1;
    b_dv = n_dv;
    send_frame(8'hA5, 32, 1'b1, 1'b1, 1'b1, st);
    idle(6);
    check("odd_dv_cyc", dv_cyc[n_dv-1] - st, 353);
    check("odd_data", dv_dat[n_dv-1], 8'hA5);
    send_frame(8'h3C, 32, 1'b1, 1'b1, 1'b1, st);
    idle(6);
    check("odd_data2", dv_dat[n_dv-1], 8'h3C);
    check("odd_dv_cnt", n_dv - b_dv, 2);
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    send_frame(8'hA5, 32, 1'b1, 1'b0, 1'b1, st);
    idle(6);
    check("par_pe_cnt", n_pe - b_pe, 1);
    check("par_pe_cyc", pe_cyc - st, 353);
    check("par_no_dv", n_dv - b_dv, 0);
    check("par_no_se", n_se - b_se, 0);
    check("par_hold", P_DATA, 8'h3C);

    // P=16, no parity, stop bit 0
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, st);
    idle(6);
    check("stop_se_cnt", n_se - b_se, 1);
    check("stop_se_cyc", se_cyc - st, 161);
    check("stop_no_dv", n_dv - b_dv, 0);
    check("stop_no_pe", n_pe - b_pe, 0);

    // Glitch: 3 low cycles, then a good frame must still decode
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(10);
    check("glitch_quiet", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, st);
    idle(6);
    check("glitch_after_cyc", dv_cyc[n_dv-1] - st, 161);
    check("glitch_after_data", dv_dat[n_dv-1], 8'hC3);

    // Back-to-back frames, no idle gap
    b_dv = n_dv;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, st);
    send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, st2);
    idle(6);
    check("b2b_cnt", n_dv - b_dv, 2);
    check("b2b_first_cyc", dv_cyc[b_dv] - st, 161);
    check("b2b_spacing", dv_cyc[b_dv+1] - dv_cyc[b_dv], 160);
    check("b2b_data0", dv_dat[b_dv], 8'h3C);
    check("b2b_data1", dv_dat[b_dv+1], 8'hFF);

    // Reset during data bit 4 of a 0x55 frame
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16); drive_bit(1'b0, 16); drive_bit(1'b1, 16); drive_bit(1'b0, 16);
    RX_IN = 1'b1;
    repeat (8) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_pdata", P_DATA, 8'h00);
    check("mid_rst_flags", {data_valid, parity_error, stop_error}, 3'b000);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    idle(40);
    check("mid_rst_quiet", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);
    check("mid_rst_pdata_after", P_DATA, 8'h00);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, st);
    idle(6);
    check("mid_rst_dv_cnt", n_dv - b_dv, 1);
    check("mid_rst_data", dv_dat[n_dv-1], 8'h81);
    check("mid_rst_dv_cyc", dv_cyc[n_dv-1] - st, 161);

    // Combined parity and stop errors, P=8 even parity (0x0F -> parity 0, send 1)
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b0, st);
    idle(6);
    check("comb_pe_cnt", n_pe - b_pe, 1);
    check("comb_se_cnt", n_se - b_se, 1);
    check("comb_pe_cyc", pe_cyc - st, 89);
    check("comb_same_cyc", se_cyc - pe_cyc, 0);
    check("comb_no_dv", n_dv - b_dv, 0);

    // Illegal Prescale behaves as 8
    Prescale = 6'd12; PAR_EN = 1'b0;
    b_dv = n_dv;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, st);
    idle(6);
    check("illegal_p_cnt", n_dv - b_dv, 1);
    check("illegal_p_cyc", dv_cyc[n_dv-1] - st, 81);
    check("illegal_p_data", dv_dat[n_dv-1], 8'h96);

    check("pdata_stable", bad_chg, 0);
    check("dv_exclusive", excl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side counterpart of the UART transmitter in the UART block. It oversamples the serial line `RX_IN` on `CLK`, which runs at Prescale × baud rate, and detects the start bit. It then deserializes `DATA_WIDTH` data bits LSB first, optionally checks parity, and checks the stop bit. A complete, error-free frame is presented on `P_DATA` with a one-cycle `data_valid` pulse toward the system-side synchronizer.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `CLK`  in  1  oversampling clock (Prescale × baud).
- `RST`  in  1  reset; asynchronous, active-low.
- `RX_IN`  in  1  serial line, idle high; already synchronized to `CLK`.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `Prescale`  in  6  oversampling ratio; legal values are 8, 16 and 32.
- `P_DATA`  out  DATA_WIDTH  last good received word.
- `data_valid`  out  1  one-cycle pulse when `P_DATA` is updated.
- `parity_error`  out  1  one-cycle pulse at frame end on parity mismatch.
- `stop_error`  out  1  one-cycle pulse at frame end when the stop bit is sampled 0.

## Operation
- **Reset values:** all outputs 0, state IDLE, counters 0, shift register 0.
- **Configuration capture:** `Prescale`, `PAR_EN` and `PAR_TYP` are captured on leaving IDLE and held for the whole frame. Any illegal `Prescale` value behaves as 8.
- **Counters:**
  - `edge_cnt` runs 0..P-1 within each bit, where P is the captured Prescale. It wraps to 0 at P-1.
  - `bit_cnt` counts the bits of the current field.
- **Sampling:** the line is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples and is final at `edge_cnt` = P/2+1.
- **States:**
  - IDLE: when `RX_IN` = 0, go to START with `edge_cnt` = 0 on the next cycle. Otherwise stay in IDLE.
  - START: if the majority sample is 1 (glitch), return to IDLE at `edge_cnt` = P/2+1+1 and produce no outputs. Otherwise, at `edge_cnt` = P-1, go to DATA.
  - DATA: shift the sampled bit into the MSB of the shift register (LSB-first line order). After `DATA_WIDTH` bits, at `edge_cnt` = P-1, go to PARITY if `PAR_EN`, else to STOP.
  - PARITY: compare the sampled bit with the expected bit. Expected = XOR of the data bits when `PAR_TYP` = 0, XNOR when `PAR_TYP` = 1. A mismatch sets an internal parity-fail flag. At `edge_cnt` = P-1, go to STOP.
  - STOP: sample the bit; a sampled 0 sets an internal stop-fail flag. At `edge_cnt` = P-1, go to IDLE and issue the frame result.
- **Frame result** (the cycle after STOP `edge_cnt` = P-1):
  - If neither fail flag is set: `P_DATA` <= shift register and `data_valid` = 1.
  - Otherwise: `P_DATA` holds its old value, and `parity_error` and/or `stop_error` pulse. Both may pulse together.
  - Fail flags clear on entry to START.
- **Back-to-back frames:** a start bit immediately following the stop bit is detected in the first IDLE cycle. No idle gap is required.
- **Reset mid-frame:** the frame is abandoned, all state returns to reset values, and nothing is output for the partial frame.
- **Line not returning high:** `RX_IN` stuck at 0 after a stop error restarts START each frame time. Each false frame ends with `stop_error` and no `data_valid`.

## Timing
- Frame length F = P × (2 + `DATA_WIDTH` + `PAR_EN`) cycles, measured from the cycle IDLE sees `RX_IN` = 0.
- The result pulse occurs at cycle F+1 after the falling edge is seen in IDLE.
- `data_valid`, `parity_error` and `stop_error` are registered, exactly 1 cycle wide, and mutually exclusive with `data_valid`.
- `P_DATA` changes only in the cycle `data_valid` is high and is stable otherwise.
- Glitch rejection: a low pulse shorter than P/2-1 cycles never produces output.

## Test plan
- **Good frame, even parity:** P=8, `PAR_EN`=1, `PAR_TYP`=0, frame 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 (0xA5) -> `data_valid` pulse at cycle 89, `P_DATA` = 0xA5, no errors.
- **Odd parity, 32× oversampling:** P=32, `PAR_TYP`=1, data 0xA5 with parity bit 1 -> `P_DATA` = 0xA5. The same frame with parity bit 0 -> `parity_error` pulse, no `data_valid`, `P_DATA` keeps its previous value.
- **Stop error and glitch:** P=16, `PAR_EN`=0, data 0x3C with stop bit 0 -> `stop_error` pulse only. `RX_IN` low for 3 cycles then high -> no output, FSM back in IDLE within 10 cycles.
- **Back-to-back frames:** P=16, `PAR_EN`=0, frames 0x3C then 0xFF with no gap -> two `data_valid` pulses exactly 160 cycles apart, `P_DATA` = 0x3C then 0xFF.
- **Reset mid-frame:** `RST` asserted during DATA bit 4, released, then a clean 0x81 frame sent -> all outputs 0 during and after reset, then one `data_valid` with `P_DATA` = 0x81.
- **Combined errors:** P=8, bad parity and bad stop in the same frame -> `parity_error` and `stop_error` pulse in the same cycle, `data_valid` stays 0.
